// File: rtl/hex_display_bank_if.sv
// Bundle of controller-side inputs, ROM port and digit outputs for hex_display_bank.
interface hex_display_bank_if #(
    parameter int NUM_DIGITS = 4,
    parameter int ADDR_W     = 6
);
    logic [1:0]              mode;
    logic                    prompt_is_pass;
    logic [3:0]              prompt_index;
    logic [3:0]              switch_val;
    logic [2:0]              msg_code;
    logic                    next_pulse;
    logic [ADDR_W-1:0]       rom_addr;
    logic [4*NUM_DIGITS-1:0] rom_data;
    logic [7*NUM_DIGITS-1:0] seg_out;
    logic                    busy;

    modport master (
        output mode, prompt_is_pass, prompt_index, switch_val, msg_code, next_pulse, rom_data,
        input  rom_addr, seg_out, busy
    );

    modport slave (
        input  mode, prompt_is_pass, prompt_index, switch_val, msg_code, next_pulse, rom_data,
        output rom_addr, seg_out, busy
    );
endinterface

// File: rtl/hex_display_bank.sv
// Registered driver for a bank of active-low seven-segment digits: blank, prompt,
// message and ROM-record browsing modes.
module hex_display_bank #(
    parameter int NUM_DIGITS      = 4,
    parameter int NUM_ENTRIES     = 6,
    parameter int ADDR_W          = 6,
    parameter int ROM_LATENCY     = 2,
    parameter int AUTO_ADV_CYCLES = 0
) (
    input  logic clk,
    input  logic rst,
    hex_display_bank_if.slave bus
);
    localparam int CW = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
    localparam int TW = (AUTO_ADV_CYCLES > 1) ? $clog2(AUTO_ADV_CYCLES) : 1;
    localparam logic [CW-1:0]     CNT_LAST   = CW'(ROM_LATENCY - 1);
    localparam logic [TW-1:0]     TIMER_LAST = TW'((AUTO_ADV_CYCLES > 0) ? AUTO_ADV_CYCLES - 1 : 0);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(NUM_ENTRIES - 1);
    localparam bit                AUTO_EN    = (AUTO_ADV_CYCLES > 0);

    localparam logic [6:0] G_OFF = 7'b1111111;
    localparam logic [6:0] G_U = 7'b1000001, G_P = 7'b0001100, G_F = 7'b0001110;
    localparam logic [6:0] G_I = 7'b1111001, G_S = 7'b0010010, G_H = 7'b0001001;
    localparam logic [6:0] G_B = 7'b0000011, G_O = 7'b1000000, G_T = 7'b0000111;
    localparam logic [6:0] G_L = 7'b1000111, G_E = 7'b0000110, G_D = 7'b0100001;
    localparam logic [6:0] G_N = 7'b0101011;

    typedef enum logic [1:0] {IDLE, FETCH, SHOW} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [TW-1:0]           timer;
    logic [ADDR_W-1:0]       addr_q;
    logic [7*NUM_DIGITS-1:0] seg_q;
    logic                    busy_q;
    logic [7*NUM_DIGITS-1:0] static_glyphs;
    logic [7*NUM_DIGITS-1:0] rom_glyphs;
    logic                    auto_fire;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0: hex_glyph = 7'b1000000;
            4'h1: hex_glyph = 7'b1111001;
            4'h2: hex_glyph = 7'b0100100;
            4'h3: hex_glyph = 7'b0110000;
            4'h4: hex_glyph = 7'b0011001;
            4'h5: hex_glyph = 7'b0010010;
            4'h6: hex_glyph = 7'b0000010;
            4'h7: hex_glyph = 7'b1111000;
            4'h8: hex_glyph = 7'b0000000;
            4'h9: hex_glyph = 7'b0010000;
            4'hA: hex_glyph = 7'b0001000;
            4'hB: hex_glyph = 7'b0000011;
            4'hC: hex_glyph = 7'b1000110;
            4'hD: hex_glyph = 7'b0100001;
            4'hE: hex_glyph = 7'b0000110;
            default: hex_glyph = 7'b0001110;
        endcase
    endfunction

    function automatic logic [27:0] message_word(input logic [2:0] code);
        case (code)
            3'd1:    message_word = {G_F, G_I, G_S, G_H};
            3'd2:    message_word = {G_B, G_O, G_O, G_T};
            3'd3:    message_word = {G_L, G_O, G_S, G_E};
            3'd4:    message_word = {G_D, G_O, G_N, G_E};
            default: message_word = {4{G_OFF}};
        endcase
    endfunction

    // Display contents for the non-browse modes; only the low four digits are ever lit.
    always_comb begin
        static_glyphs = '1;
        case (bus.mode)
            2'd1: begin
                static_glyphs[7*3 +: 7] = bus.prompt_is_pass ? G_P : G_U;
                static_glyphs[7*2 +: 7] = hex_glyph(bus.prompt_index);
                static_glyphs[6:0]      = hex_glyph(bus.switch_val);
            end
            2'd2:    static_glyphs[27:0] = message_word(bus.msg_code);
            default: ;
        endcase
    end

    always_comb begin
        rom_glyphs = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            rom_glyphs[7*k +: 7] = hex_glyph(bus.rom_data[4*k +: 4]);
        end
    end

    assign auto_fire = AUTO_EN && (timer == TIMER_LAST);

    // Leaving browse mode at any point aborts the fetch; the pending record is never captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            timer  <= '0;
            addr_q <= '0;
            seg_q  <= '1;
            busy_q <= 1'b0;
        end else if (bus.mode != 2'd3) begin
            state  <= IDLE;
            cnt    <= '0;
            timer  <= '0;
            seg_q  <= static_glyphs;
            busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    addr_q <= '0;
                    cnt    <= '0;
                    timer  <= '0;
                    seg_q  <= '1;
                    busy_q <= 1'b1;
                    state  <= FETCH;
                end
                FETCH: begin
                    timer <= '0;
                    if (cnt == CNT_LAST) begin
                        seg_q  <= rom_glyphs;
                        busy_q <= 1'b0;
                        state  <= SHOW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (bus.next_pulse || auto_fire) begin
                        addr_q <= (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
                        cnt    <= '0;
                        timer  <= '0;
                        busy_q <= 1'b1;
                        state  <= FETCH;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rom_addr = addr_q;
    assign bus.seg_out  = seg_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_hex_display_bank.sv
// Randomised bench for hex_display_bank: a behavioural display model is checked every
// cycle, with literal expectations from hand-worked cases pinning the model.
module tb_hex_display_bank;
    localparam int ND   = 5;
    localparam int NE   = 6;
    localparam int AW   = 6;
    localparam int RL   = 2;
    localparam int AUTO = 10;

    logic clk;
    logic rst;

    hex_display_bank_if #(.NUM_DIGITS(ND), .ADDR_W(AW)) bus ();

    hex_display_bank #(
        .NUM_DIGITS(ND), .NUM_ENTRIES(NE), .ADDR_W(AW),
        .ROM_LATENCY(RL), .AUTO_ADV_CYCLES(AUTO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [6:0] hex_font [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    string msgs [8] = '{"    ", "FISH", "bOOt", "LOSE", "dOnE", "    ", "    ", "    "};

    // Synchronous ROM with one output register: data for an address is usable two edges on.
    logic [4*ND-1:0] rom [64];
    logic [4*ND-1:0] rom_q;
    always @(posedge clk) rom_q <= rom[bus.rom_addr];
    assign bus.rom_data = rom_q;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 0;

    int m_phase = 0;
    int m_wait  = 0;
    int m_show  = 0;
    int m_addr  = 0;
    logic [7*ND-1:0] exp_seg  = '1;
    logic            exp_busy = 1'b0;

    function automatic logic [6:0] letter(input byte c);
        case (c)
            "U": letter = 7'b1000001;
            "P": letter = 7'b0001100;
            "F": letter = 7'b0001110;
            "I": letter = 7'b1111001;
            "S": letter = 7'b0010010;
            "H": letter = 7'b0001001;
            "b": letter = 7'b0000011;
            "O": letter = 7'b1000000;
            "t": letter = 7'b0000111;
            "L": letter = 7'b1000111;
            "E": letter = 7'b0000110;
            "d": letter = 7'b0100001;
            "n": letter = 7'b0101011;
            default: letter = 7'b1111111;
        endcase
    endfunction

    function automatic logic [7*ND-1:0] static_display(input int md, input bit pass,
                                                       input int idx, input int sw, input int code);
        logic [7*ND-1:0] d = '1;
        string w;
        if (md == 1) begin
            d[7*3 +: 7] = letter(pass ? "P" : "U");
            d[7*2 +: 7] = hex_font[idx];
            d[0 +: 7]   = hex_font[sw];
        end else if (md == 2) begin
            w = msgs[code];
            for (int i = 0; i < 4; i++) d[7*(3-i) +: 7] = letter(w[i]);
        end
        return d;
    endfunction

    function automatic logic [7*ND-1:0] record_display(input logic [4*ND-1:0] word);
        logic [7*ND-1:0] d;
        for (int k = 0; k < ND; k++) d[7*k +: 7] = hex_font[word[4*k +: 4]];
        return d;
    endfunction

    function automatic logic [6:0] digit(input int k);
        return bus.seg_out[7*k +: 7];
    endfunction

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        check_val("seg_out", 64'(bus.seg_out), 64'(exp_seg));
        check_val("busy", 64'(bus.busy), 64'(exp_busy));
        if (m_phase != 0) check_val("rom_addr", 64'(bus.rom_addr), 64'(m_addr));
    endtask

    task automatic applyStimulus(input int md, input bit pass, input int idx, input int sw,
                                 input int code, input bit nxt);
        @(negedge clk);
        bus.mode           = 2'(md);
        bus.prompt_is_pass = pass;
        bus.prompt_index   = 4'(idx);
        bus.switch_val     = 4'(sw);
        bus.msg_code       = 3'(code);
        bus.next_pulse     = nxt;
    endtask

    task automatic wait_show(input string name);
        int n = 0;
        while (m_phase != 2 && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        if (m_phase != 2) check_val({name, "_timeout"}, 64'(m_phase), 64'd2);
    endtask

    // Reference: browse is modelled as phases (off / fetching with edges remaining / showing).
    task automatic model_step();
        if (rst) begin
            m_phase = 0; m_addr = 0; exp_seg = '1; exp_busy = 0; check_en = 1;
        end else if (bus.mode != 2'd3) begin
            m_phase = 0; exp_busy = 0;
            exp_seg = static_display(int'(bus.mode), bus.prompt_is_pass, int'(bus.prompt_index),
                                     int'(bus.switch_val), int'(bus.msg_code));
        end else if (m_phase == 0) begin
            m_phase = 1; m_addr = 0; m_wait = RL; exp_busy = 1; exp_seg = '1;
        end else if (m_phase == 1) begin
            m_wait--;
            if (m_wait == 0) begin
                m_phase = 2; m_show = 0; exp_busy = 0; exp_seg = record_display(rom[m_addr]);
            end
        end else begin
            m_show++;
            if (bus.next_pulse || (AUTO > 0 && m_show == AUTO)) begin
                m_addr = (m_addr + 1) % NE; m_phase = 1; m_wait = RL; exp_busy = 1;
            end
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (check_en) checkOutput();
    end

    initial begin
        int exp_addrs [6] = '{1, 2, 3, 4, 5, 0};
        int a0;
        int n;
        int cur_mode;

        for (int i = 0; i < 64; i++) rom[i] = 20'($urandom);
        rom[0] = 20'h51234;
        rst = 1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        check_val("reset_seg", 64'(bus.seg_out), 64'({7*ND{1'b1}}));
        check_val("reset_busy", 64'(bus.busy), 64'd0);
        check_val("reset_addr", 64'(bus.rom_addr), 64'd0);
        @(negedge clk) rst = 0;

        applyStimulus(1, 0, 2, 4'hA, 0, 0);
        @(posedge clk); #2;
        check_val("prompt_d3", 64'(digit(3)), 64'(7'b1000001));
        check_val("prompt_d2", 64'(digit(2)), 64'(7'b0100100));
        check_val("prompt_d1", 64'(digit(1)), 64'(7'b1111111));
        check_val("prompt_d0", 64'(digit(0)), 64'(7'b0001000));
        check_val("prompt_d4", 64'(digit(4)), 64'(7'b1111111));

        applyStimulus(2, 0, 0, 0, 1, 0);
        @(posedge clk); #2;
        check_val("fish", 64'(bus.seg_out[27:0]), 64'({7'b0001110, 7'b1111001, 7'b0010010, 7'b0001001}));
        applyStimulus(2, 0, 0, 0, 3, 0);
        #1;
        check_val("lose_not_early", 64'(digit(3)), 64'(7'b0001110));
        @(posedge clk); #2;
        check_val("lose", 64'(bus.seg_out[27:0]), 64'({7'b1000111, 7'b1000000, 7'b0010010, 7'b0000110}));
        applyStimulus(2, 0, 0, 0, 6, 0);
        @(posedge clk); #2;
        check_val("msg6_off", 64'(bus.seg_out), 64'({7*ND{1'b1}}));

        applyStimulus(3, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        check_val("entry_busy", 64'(bus.busy), 64'd1);
        check_val("entry_blank", 64'(bus.seg_out), 64'({7*ND{1'b1}}));
        @(posedge clk); #2;
        check_val("entry_busy2", 64'(bus.busy), 64'd1);
        @(posedge clk); #2;
        check_val("rec0_busy", 64'(bus.busy), 64'd0);
        check_val("rec0_digits", 64'(bus.seg_out[27:0]),
                  64'({7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}));
        check_val("rec0_d4", 64'(digit(4)), 64'(7'b0010010));
        check_val("rec0_addr", 64'(bus.rom_addr), 64'd0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(3, 0, 0, 0, 0, 1);
            applyStimulus(3, 0, 0, 0, 0, 1);
            applyStimulus(3, 0, 0, 0, 0, 0);
            wait_show("step");
            check_val("step_addr", 64'(bus.rom_addr), 64'(exp_addrs[i]));
        end

        applyStimulus(3, 0, 0, 0, 0, 0);
        repeat (30) @(posedge clk);
        n = 0;
        @(negedge clk);
        while (!(m_phase == 2 && m_show == AUTO - 1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("coincide_reached", 64'(n < 40), 64'd1);
        a0 = m_addr;
        bus.next_pulse = 1;
        @(posedge clk); #2;
        check_val("coincide_addr", 64'(bus.rom_addr), 64'((a0 + 1) % NE));
        @(negedge clk) bus.next_pulse = 0;
        @(posedge clk); #2;
        check_val("coincide_single", 64'(bus.rom_addr), 64'((a0 + 1) % NE));

        n = 0;
        @(negedge clk);
        while (!(m_phase == 1 && m_addr == 3) && n < 200) begin
            bus.next_pulse = (m_phase == 2);
            @(negedge clk);
            n++;
        end
        check_val("abort_reached", 64'(n < 200), 64'd1);
        bus.next_pulse = 0;
        bus.mode = 2'd2;
        bus.msg_code = 3'd4;
        @(posedge clk); #2;
        check_val("abort_msg", 64'(bus.seg_out[27:0]),
                  64'({7'b0100001, 7'b1000000, 7'b0101011, 7'b0000110}));
        check_val("abort_busy", 64'(bus.busy), 64'd0);
        applyStimulus(3, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        check_val("reentry_addr", 64'(bus.rom_addr), 64'd0);
        check_val("reentry_blank", 64'(bus.seg_out), 64'({7*ND{1'b1}}));
        wait_show("reentry");
        @(negedge clk) rst = 1;
        @(posedge clk); #2;
        check_val("rst_show_seg", 64'(bus.seg_out), 64'({7*ND{1'b1}}));
        check_val("rst_show_busy", 64'(bus.busy), 64'd0);
        @(negedge clk) rst = 0;

        cur_mode = 3;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 99) < 4)
                cur_mode = ($urandom_range(0, 1) == 0) ? 3 : int'($urandom_range(0, 2));
            applyStimulus(cur_mode, 1'($urandom), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                          $urandom_range(0, 99) < 20);
            rst = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk) rst = 0;
        repeat (3) @(posedge clk);
        #2;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
